cond_exec_stage: RTL and testbench
==================================

# cond_exec_stage

Execute-stage control register and conditional-execution unit of the pipelined core. It latches the decode-stage control word into the E stage, supporting stall and flush. It evaluates the instruction condition field against the architectural NZCV register and gates every side effect of the instruction. It also owns and updates the NZCV flag register from ALU results.

## Interface
- No parameters.
- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- StallE  in  1  hold E-stage register contents
- FlushE  in  1  load a bubble into E-stage register
- CondD  in  4  instruction condition field, InstrD[31:28]
- PCSrcD, RegWriteD, MemWriteD, MemtoRegD, ALUSrcD, BranchD  in  1 each  decoded control bits
- FlagWriteD  in  2  [1] = write N,Z; [0] = write C,V
- ALUControlD  in  6  decoded operation code
- ALUFlags  in  4  {N,Z,C,V} produced by ALU for the instruction currently in E
- ALUControlE  out  6  registered op code to ALU
- ALUSrcE, MemtoRegE  out  1 each  registered, ungated
- FlagsE  out  4  current architectural NZCV (carry-in for ADC/SBC/RRX)
- CondExE  out  1  condition passed for instruction in E
- PCSrcE, RegWriteE, MemWriteE  out  1 each  registered bit AND CondExE
- BranchTakenE  out  1  branch redirect request
- LinkE  out  1  BL executed; write return address to link register

## Operation
- E register holds CondE, PCSrcE_r, RegWriteE_r, MemWriteE_r, MemtoRegE, ALUSrcE, BranchE_r, FlagWriteE_r, ALUControlE.
- Update priority each edge: reset, then FlushE, then StallE, then load from D.
  - FlushE: all control bits 0, ALUControlE = 0, CondE = 4'b1110.
  - StallE: hold all fields.
- CondExE is decoded from CondE and the registered NZCV:
  - 0000 EQ Z; 0001 NE ~Z; 0010 CS C; 0011 CC ~C
  - 0100 MI N; 0101 PL ~N; 0110 VS V; 0111 VC ~V
  - 1000 HI C&~Z; 1001 LS ~C|Z; 1010 GE N==V; 1011 LT N!=V
  - 1100 GT ~Z&(N==V); 1101 LE Z|(N!=V)
  - 1110 AL 1; 1111 treated as always-execute (1)
- Flag register update at the edge when CondExE=1 and StallE=0:
  - FlagWriteE_r[1] loads N,Z from ALUFlags.
  - FlagWriteE_r[0] loads C,V from ALUFlags.
  - The two halves update independently.
- A flushed bubble never writes flags. A stalled instruction writes flags only on its final (non-stalled) cycle.
- Branch decode is by ALUControlE when BranchE_r=1:
  - 010000 B and 010001 BL: taken = CondExE.
  - 010010 CBZ: taken = CondExE & ALUFlags[2] (Z of the tested operand).
  - 010011 CBNZ: taken = CondExE & ~ALUFlags[2].
  - Any other code: not taken.
- BranchTakenE = BranchE_r & taken.
- LinkE = BranchE_r & CondExE & (ALUControlE==010001).

## Timing
- Reset values: E register all zero with CondE=1110; NZCV=0000. All outputs are 0 except CondExE=1 (AL bubble) and FlagsE=0000.
- Latency: D inputs appear on E outputs 1 cycle after the capturing edge.
- Gated outputs (CondExE, PCSrcE, RegWriteE, MemWriteE, BranchTakenE, LinkE) are combinational from the E register, NZCV and ALUFlags.
- New NZCV is visible on FlagsE, and to the next instruction's condition, the cycle after the writing instruction leaves E. Back-to-back CMP then BEQ therefore needs no bypass.
- FlushE and StallE both high: flush wins.
- Reset is asynchronous. Asserting reset mid-operation clears the E register and NZCV immediately, without waiting for clk.

## Test plan
- Reset, then release; no D activity: FlagsE=0000, RegWriteE=MemWriteE=PCSrcE=BranchTakenE=0, CondExE=1.
- CMP with FlagWriteD=11, CondD=1110, ALUFlags=0100 -> FlagsE=0100 next cycle. Then BEQ (BranchD=1, ALUControlD=010000, CondD=0000) -> BranchTakenE=1.
- ADDS with CondD=0001 (NE) while Z=1, RegWriteD=1, FlagWriteD=11 -> CondExE=0, RegWriteE=0, NZCV unchanged.
- FlagWriteD=10 with ALUFlags=1011, starting from NZCV=0011 -> FlagsE=1011; C,V retained because [0]=0.
- CBNZ with ALUFlags Z=0 -> BranchTakenE=1, LinkE=0. CBZ with the same flags -> BranchTakenE=0.
- Load RegWriteD=1 and FlagWriteD=11, then StallE=1 for 2 cycles -> outputs held and NZCV written once. Next, FlushE=StallE=1 -> bubble loaded, RegWriteE=0.

Source files
------------

// File: rtl/cond_exec_stage_if.sv
// Decode-to-execute control bundle for the conditional-execution stage.
// The master drives the decoded D-stage word and ALU flags, and the slave returns the gated E-stage controls.
interface cond_exec_stage_if;
  logic       StallE;
  logic       FlushE;
  logic [3:0] CondD;
  logic       PCSrcD;
  logic       RegWriteD;
  logic       MemWriteD;
  logic       MemtoRegD;
  logic       ALUSrcD;
  logic       BranchD;
  logic [1:0] FlagWriteD;
  logic [5:0] ALUControlD;
  logic [3:0] ALUFlags;
  logic [5:0] ALUControlE;
  logic       ALUSrcE;
  logic       MemtoRegE;
  logic [3:0] FlagsE;
  logic       CondExE;
  logic       PCSrcE;
  logic       RegWriteE;
  logic       MemWriteE;
  logic       BranchTakenE;
  logic       LinkE;

  modport master (
    output StallE, FlushE, CondD, PCSrcD, RegWriteD, MemWriteD, MemtoRegD,
           ALUSrcD, BranchD, FlagWriteD, ALUControlD, ALUFlags,
    input  ALUControlE, ALUSrcE, MemtoRegE, FlagsE, CondExE, PCSrcE,
           RegWriteE, MemWriteE, BranchTakenE, LinkE
  );

  modport slave (
    input  StallE, FlushE, CondD, PCSrcD, RegWriteD, MemWriteD, MemtoRegD,
           ALUSrcD, BranchD, FlagWriteD, ALUControlD, ALUFlags,
    output ALUControlE, ALUSrcE, MemtoRegE, FlagsE, CondExE, PCSrcE,
           RegWriteE, MemWriteE, BranchTakenE, LinkE
  );
endinterface

// File: rtl/cond_exec_stage.sv
// E-stage control register with condition evaluation, NZCV ownership and branch/link decode.
// Every side effect of the instruction in E is gated by its condition result.
module cond_exec_stage (
  input logic              clk,
  input logic              reset,
  cond_exec_stage_if.slave bus
);
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [5:0] OP_B    = 6'b010000;
  localparam logic [5:0] OP_BL   = 6'b010001;
  localparam logic [5:0] OP_CBZ  = 6'b010010;
  localparam logic [5:0] OP_CBNZ = 6'b010011;

  logic [3:0] condE;
  logic       pcSrcReg;
  logic       regWriteReg;
  logic       memWriteReg;
  logic       memtoRegE;
  logic       aluSrcE;
  logic       branchReg;
  logic [1:0] flagWriteReg;
  logic [5:0] aluControlE;
  logic [3:0] nzcv;
  logic       condEx;
  logic       taken;

  function automatic logic condPass(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, c, v;
    logic pass;
    {n, z, c, v} = flags;
    case (cond)
      4'b0000: pass = z;
      4'b0001: pass = ~z;
      4'b0010: pass = c;
      4'b0011: pass = ~c;
      4'b0100: pass = n;
      4'b0101: pass = ~n;
      4'b0110: pass = v;
      4'b0111: pass = ~v;
      4'b1000: pass = c & ~z;
      4'b1001: pass = ~c | z;
      4'b1010: pass = (n == v);
      4'b1011: pass = (n != v);
      4'b1100: pass = ~z & (n == v);
      4'b1101: pass = z | (n != v);
      default: pass = 1'b1;
    endcase
    return pass;
  endfunction

  // D -> E register: flush beats stall, and a bubble is an always-execute no-op
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      condE        <= COND_AL;
      pcSrcReg     <= 1'b0;
      regWriteReg  <= 1'b0;
      memWriteReg  <= 1'b0;
      memtoRegE    <= 1'b0;
      aluSrcE      <= 1'b0;
      branchReg    <= 1'b0;
      flagWriteReg <= 2'b00;
      aluControlE  <= 6'd0;
    end else if (bus.FlushE) begin
      condE        <= COND_AL;
      pcSrcReg     <= 1'b0;
      regWriteReg  <= 1'b0;
      memWriteReg  <= 1'b0;
      memtoRegE    <= 1'b0;
      aluSrcE      <= 1'b0;
      branchReg    <= 1'b0;
      flagWriteReg <= 2'b00;
      aluControlE  <= 6'd0;
    end else if (!bus.StallE) begin
      condE        <= bus.CondD;
      pcSrcReg     <= bus.PCSrcD;
      regWriteReg  <= bus.RegWriteD;
      memWriteReg  <= bus.MemWriteD;
      memtoRegE    <= bus.MemtoRegD;
      aluSrcE      <= bus.ALUSrcD;
      branchReg    <= bus.BranchD;
      flagWriteReg <= bus.FlagWriteD;
      aluControlE  <= bus.ALUControlD;
    end
  end

  // NZCV commits only as the instruction leaves E, so a stalled one writes exactly once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      nzcv <= 4'b0000;
    end else if (condEx && !bus.StallE) begin
      if (flagWriteReg[1]) nzcv[3:2] <= bus.ALUFlags[3:2];
      if (flagWriteReg[0]) nzcv[1:0] <= bus.ALUFlags[1:0];
    end
  end

  assign condEx = condPass(condE, nzcv);

  always_comb begin
    taken = 1'b0;
    case (aluControlE)
      OP_B, OP_BL: taken = condEx;
      OP_CBZ:      taken = condEx & bus.ALUFlags[2];
      OP_CBNZ:     taken = condEx & ~bus.ALUFlags[2];
      default:     taken = 1'b0;
    endcase
  end

  assign bus.ALUControlE  = aluControlE;
  assign bus.ALUSrcE      = aluSrcE;
  assign bus.MemtoRegE    = memtoRegE;
  assign bus.FlagsE       = nzcv;
  assign bus.CondExE      = condEx;
  assign bus.PCSrcE       = pcSrcReg & condEx;
  assign bus.RegWriteE    = regWriteReg & condEx;
  assign bus.MemWriteE    = memWriteReg & condEx;
  assign bus.BranchTakenE = branchReg & taken;
  assign bus.LinkE        = branchReg & condEx & (aluControlE == OP_BL);
endmodule

// File: tb/tb_cond_exec_stage.sv
// Directed bench for cond_exec_stage: a vector table for single-cycle behaviour plus
// hand sequences for stall, flush-over-stall and asynchronous reset.
module tb_cond_exec_stage;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  cond_exec_stage_if ifc ();

  cond_exec_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ctl = {PCSrc, RegWrite, MemWrite, MemtoReg, ALUSrc, Branch}
  // eOut = {CondExE, PCSrcE, RegWriteE, MemWriteE, MemtoRegE, ALUSrcE, BranchTakenE, LinkE}
  typedef struct {
    logic [3:0] cond;
    logic [5:0] ctl;
    logic [1:0] fw;
    logic [5:0] aluc;
    logic [3:0] alu;
    logic [7:0] eOut;
    logic [3:0] eFlags;
    logic [5:0] eAluc;
  } vec_t;

  vec_t vecs[15];

  function automatic logic [7:0] outVec();
    return {ifc.CondExE, ifc.PCSrcE, ifc.RegWriteE, ifc.MemWriteE,
            ifc.MemtoRegE, ifc.ALUSrcE, ifc.BranchTakenE, ifc.LinkE};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic driveD(input logic [3:0] cond, input logic [5:0] ctl,
                        input logic [1:0] fw, input logic [5:0] aluc);
    ifc.CondD = cond;
    {ifc.PCSrcD, ifc.RegWriteD, ifc.MemWriteD, ifc.MemtoRegD, ifc.ALUSrcD, ifc.BranchD} = ctl;
    ifc.FlagWriteD = fw;
    ifc.ALUControlD = aluc;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    ifc.StallE = 1'b0;
    ifc.FlushE = 1'b0;
    ifc.ALUFlags = 4'b0000;
    driveD(4'b1110, 6'b000000, 2'b00, 6'd0);

    vecs[0]  = '{4'b1110, 6'b000000, 2'b11, 6'b000010, 4'b0100, 8'b1000_0000, 4'b0000, 6'b000010};
    vecs[1]  = '{4'b0000, 6'b100001, 2'b00, 6'b010000, 4'b0000, 8'b1100_0010, 4'b0100, 6'b010000};
    vecs[2]  = '{4'b0001, 6'b010000, 2'b11, 6'b000100, 4'b0011, 8'b0000_0000, 4'b0100, 6'b000100};
    vecs[3]  = '{4'b1110, 6'b000000, 2'b11, 6'b000000, 4'b0011, 8'b1000_0000, 4'b0100, 6'b000000};
    vecs[4]  = '{4'b1110, 6'b000000, 2'b10, 6'b000000, 4'b1011, 8'b1000_0000, 4'b0011, 6'b000000};
    vecs[5]  = '{4'b1110, 6'b000001, 2'b00, 6'b010011, 4'b0000, 8'b1000_0010, 4'b1011, 6'b010011};
    vecs[6]  = '{4'b1110, 6'b000001, 2'b00, 6'b010010, 4'b0000, 8'b1000_0000, 4'b1011, 6'b010010};
    vecs[7]  = '{4'b1010, 6'b010001, 2'b00, 6'b010001, 4'b0000, 8'b1010_0011, 4'b1011, 6'b010001};
    vecs[8]  = '{4'b1011, 6'b010001, 2'b00, 6'b010001, 4'b0000, 8'b0000_0000, 4'b1011, 6'b010001};
    vecs[9]  = '{4'b1001, 6'b001110, 2'b00, 6'b000000, 4'b0000, 8'b0000_1100, 4'b1011, 6'b000000};
    vecs[10] = '{4'b1000, 6'b001110, 2'b00, 6'b000000, 4'b0000, 8'b1001_1100, 4'b1011, 6'b000000};
    vecs[11] = '{4'b1100, 6'b000001, 2'b00, 6'b010100, 4'b0000, 8'b1000_0000, 4'b1011, 6'b010100};
    vecs[12] = '{4'b1111, 6'b010000, 2'b00, 6'b000011, 4'b0000, 8'b1010_0000, 4'b1011, 6'b000011};
    vecs[13] = '{4'b1110, 6'b000001, 2'b00, 6'b010010, 4'b0100, 8'b1000_0010, 4'b1011, 6'b010010};
    vecs[14] = '{4'b0000, 6'b000001, 2'b00, 6'b010000, 4'b0000, 8'b0000_0000, 4'b1011, 6'b010000};

    // Reset held, then released with an idle AL stream on D
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", {24'd0, outVec()}, {24'd0, 8'b1000_0000});
    chk("rst_flags", {28'd0, ifc.FlagsE}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #2;
    chk("idle_out", {24'd0, outVec()}, {24'd0, 8'b1000_0000});
    chk("idle_flags", {28'd0, ifc.FlagsE}, 32'd0);

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      driveD(vecs[i].cond, vecs[i].ctl, vecs[i].fw, vecs[i].aluc);
      @(posedge clk);
      #1 ifc.ALUFlags = vecs[i].alu;
      #1;
      chk($sformatf("vec%0d_out", i), {24'd0, outVec()}, {24'd0, vecs[i].eOut});
      chk($sformatf("vec%0d_flags", i), {28'd0, ifc.FlagsE}, {28'd0, vecs[i].eFlags});
      chk($sformatf("vec%0d_aluc", i), {26'd0, ifc.ALUControlE}, {26'd0, vecs[i].eAluc});
    end

    // Flag-writing instruction held for two stall cycles; ALU flags change meanwhile
    @(negedge clk);
    driveD(4'b1110, 6'b010000, 2'b11, 6'd5);
    @(posedge clk);
    #1 ifc.ALUFlags = 4'b0100;
    #1 chk("stall_load_rw", {31'd0, ifc.RegWriteE}, 32'd1);
    @(negedge clk);
    ifc.StallE = 1'b1;
    driveD(4'b1110, 6'b000000, 2'b00, 6'd7);
    @(posedge clk);
    #1 ifc.ALUFlags = 4'b0110;
    #1;
    chk("stall1_rw", {31'd0, ifc.RegWriteE}, 32'd1);
    chk("stall1_aluc", {26'd0, ifc.ALUControlE}, 32'd5);
    chk("stall1_flags", {28'd0, ifc.FlagsE}, {28'd0, 4'b1011});
    @(posedge clk);
    #2;
    chk("stall2_aluc", {26'd0, ifc.ALUControlE}, 32'd5);
    chk("stall2_flags", {28'd0, ifc.FlagsE}, {28'd0, 4'b1011});
    @(negedge clk);
    ifc.StallE = 1'b0;
    @(posedge clk);
    #2;
    chk("unstall_flags", {28'd0, ifc.FlagsE}, {28'd0, 4'b0110});
    chk("unstall_aluc", {26'd0, ifc.ALUControlE}, 32'd7);
    chk("unstall_rw", {31'd0, ifc.RegWriteE}, 32'd0);

    // Flush with stall: bubble loads and the displaced instruction writes no flags
    @(negedge clk);
    driveD(4'b0000, 6'b010000, 2'b11, 6'd9);
    @(posedge clk);
    #1 ifc.ALUFlags = 4'b0000;
    #1 chk("pre_flush_rw", {31'd0, ifc.RegWriteE}, 32'd1);
    @(negedge clk);
    ifc.FlushE = 1'b1;
    ifc.StallE = 1'b1;
    @(posedge clk);
    #2;
    chk("flush_out", {24'd0, outVec()}, {24'd0, 8'b1000_0000});
    chk("flush_aluc", {26'd0, ifc.ALUControlE}, 32'd0);
    chk("flush_flags", {28'd0, ifc.FlagsE}, {28'd0, 4'b0110});
    @(negedge clk);
    ifc.StallE = 1'b0;
    @(posedge clk);
    #2 chk("bubble_flags", {28'd0, ifc.FlagsE}, {28'd0, 4'b0110});

    // Reset asserted between edges clears state immediately
    @(negedge clk);
    ifc.FlushE = 1'b0;
    driveD(4'b1110, 6'b010000, 2'b11, 6'd9);
    @(posedge clk);
    #1 ifc.ALUFlags = 4'b1111;
    #1 chk("pre_arst_rw", {31'd0, ifc.RegWriteE}, 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("arst_out", {24'd0, outVec()}, {24'd0, 8'b1000_0000});
    chk("arst_flags", {28'd0, ifc.FlagsE}, 32'd0);
    chk("arst_aluc", {26'd0, ifc.ALUControlE}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
